// File: rtl/param_edge_shift_register.sv
// WIDTH-bit storage element with selectable capture edge: hold, load, shift,
// rotate and modulo up/down count, with true/complement outputs and a wrap pulse.
module param_edge_shift_register #(
    parameter int              WIDTH    = 8,
    parameter bit              NEG_EDGE = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             ovf
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_SHL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ROL   = 3'b101,
        MODE_UP    = 3'b110,
        MODE_DOWN  = 3'b111
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;

    assign op = mode_t'(mode);
    assign qb = ~q;

    always_comb begin
        q_next   = q;
        ovf_next = 1'b0;
        if (en) begin
            case (op)
                MODE_HOLD: q_next = q;
                MODE_LOAD: q_next = d;
                MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
                MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
                MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
                MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_UP: begin
                    q_next   = q + WIDTH'(1);
                    ovf_next = &q;
                end
                MODE_DOWN: begin
                    q_next   = q - WIDTH'(1);
                    ovf_next = ~|q;
                end
                default: q_next = q;
            endcase
        end
    end

    // Only one branch elaborates, so q/ovf have a single driver on the chosen edge.
    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge clk or posedge rst) begin
            if (rst) begin
                q   <= RST_VAL;
                ovf <= 1'b0;
            end else begin
                q   <= q_next;
                ovf <= ovf_next;
            end
        end
    end else begin : g_pos
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q   <= RST_VAL;
                ovf <= 1'b0;
            end else begin
                q   <= q_next;
                ovf <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_param_edge_shift_register.sv
// Directed and random checks of a falling-edge and a rising-edge instance
// against an arithmetic reference model.
module tb_param_edge_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;

    logic [7:0] q_n, qb_n, q_p, qb_p;
    logic       ovf_n, ovf_p;

    logic [7:0] mq_n, mq_p;
    logic       movf_n, movf_p;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] RV_N = 8'h5A;
    localparam logic [7:0] RV_P = 8'hC3;

    always #5 clk = ~clk;

    param_edge_shift_register #(.WIDTH(8), .NEG_EDGE(1'b1), .RST_VAL(RV_N)) dut_n (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q_n), .qb(qb_n), .ovf(ovf_n)
    );

    param_edge_shift_register #(.WIDTH(8), .NEG_EDGE(1'b0), .RST_VAL(RV_P)) dut_p (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q_p), .qb(qb_p), .ovf(ovf_p)
    );

    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic [2:0] m,
                                            input logic [7:0] dd, input logic sr, input logic sl);
        int v;
        int c;
        c = int'(cur);
        case (m)
            3'd0: v = c;
            3'd1: v = int'(dd);
            3'd2: v = c / 2 + (sr ? 128 : 0);
            3'd3: v = (c * 2) % 256 + (sl ? 1 : 0);
            3'd4: v = c / 2 + (c % 2) * 128;
            3'd5: v = (c * 2) % 256 + c / 128;
            3'd6: v = (c + 1) % 256;
            default: v = (c + 255) % 256;
        endcase
        return v[7:0];
    endfunction

    function automatic logic ref_wrap(input logic [7:0] cur, input logic [2:0] m, input logic e);
        return e && ((m == 3'd6 && int'(cur) == 255) || (m == 3'd7 && int'(cur) == 0));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("q_n",   q_n,   mq_n);
        chk("qb_n",  qb_n,  ~mq_n);
        chk("ovf_n", {7'd0, ovf_n}, {7'd0, movf_n});
        chk("q_p",   q_p,   mq_p);
        chk("qb_p",  qb_p,  ~mq_p);
        chk("ovf_p", {7'd0, ovf_p}, {7'd0, movf_p});
    endtask

    task automatic model_reset();
        mq_n = RV_N; movf_n = 1'b0;
        mq_p = RV_P; movf_p = 1'b0;
    endtask

    // Wait for the next clock edge of either polarity, advance the matching model, check both.
    task automatic tick();
        @(clk);
        if (rst) begin
            model_reset();
        end else if (clk) begin
            movf_p = ref_wrap(mq_p, mode, en);
            if (en) mq_p = ref_next(mq_p, mode, d, sin_r, sin_l);
        end else begin
            movf_n = ref_wrap(mq_n, mode, en);
            if (en) mq_n = ref_next(mq_n, mode, d, sin_r, sin_l);
        end
        #1;
        chk_all();
    endtask

    // Advance until just after a falling edge: one update of the falling-edge instance.
    task automatic cyc();
        tick();
        if (clk) tick();
    endtask

    task automatic load_n(input logic [7:0] v);
        mode = 3'b001; d = v; en = 1'b1;
        cyc();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 3'b001; d = 8'hFF; sin_r = 1'b0; sin_l = 1'b0;
        model_reset();
        #1;
        chk("rst_q",   q_n,  8'h5A);
        chk("rst_qb",  qb_n, 8'hA5);
        chk("rst_ovf", {7'd0, ovf_n}, 8'h00);
        chk_all();
        tick();
        tick();
        chk("rst_hold_fall", q_n, 8'h5A);
        rst = 1'b0;

        load_n(8'h00);
        d = 8'h3C;
        tick();
        chk("edge_rise_n", q_n, 8'h00);
        chk("edge_rise_p", q_p, 8'h3C);
        tick();
        chk("edge_fall_n", q_n, 8'h3C);

        load_n(8'h96);
        mode = 3'b010; sin_r = 1'b1; cyc(); chk("shr", q_n, 8'hCB);
        mode = 3'b011; sin_l = 1'b0; cyc(); chk("shl", q_n, 8'h96);
        mode = 3'b100; cyc(); chk("ror", q_n, 8'h4B);
        mode = 3'b101; cyc(); chk("rol", q_n, 8'h96);

        load_n(8'hFE);
        mode = 3'b110;
        cyc(); chk("up_ff", q_n, 8'hFF); chk("up_ff_ovf", {7'd0, ovf_n}, 8'h00);
        cyc(); chk("up_00", q_n, 8'h00); chk("up_00_ovf", {7'd0, ovf_n}, 8'h01);
        cyc(); chk("up_01", q_n, 8'h01); chk("up_01_ovf", {7'd0, ovf_n}, 8'h00);
        mode = 3'b111;
        cyc(); chk("dn_00", q_n, 8'h00); chk("dn_00_ovf", {7'd0, ovf_n}, 8'h00);
        cyc(); chk("dn_ff", q_n, 8'hFF); chk("dn_ff_ovf", {7'd0, ovf_n}, 8'h01);

        load_n(8'h10);
        en = 1'b0;
        for (int unsigned m = 0; m < 8; m++) begin
            mode = 3'(m);
            cyc();
            chk("en0_q", q_n, 8'h10);
            chk("en0_ovf", {7'd0, ovf_n}, 8'h00);
        end
        en = 1'b1; mode = 3'b110;
        cyc(); chk("en1_up", q_n, 8'h11);

        load_n(8'h00);
        mode = 3'b110;
        for (int unsigned i = 0; i < 5; i++) cyc();
        chk("mid_cnt", q_n, 8'h05);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst", q_n, 8'h5A);
        chk_all();
        rst = 1'b0;
        cyc();
        chk("post_rst", q_n, 8'h5B);

        for (int unsigned i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 7) != 0);
            mode  = 3'($urandom_range(0, 7));
            d     = 8'($urandom);
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                chk_all();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
